// File: rtl/core2wb_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : core2wb_bridge_pkg                                       |
// | Description : Shared defaults and bus typedefs for the core-to-        |
// |               Wishbone bridge.                                         |
// | Revision    : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package core2wb_bridge_pkg;

  localparam int c_def_aw      = 32;
  localparam int c_def_dw      = 32;
  localparam int c_def_max_out = 2;

  typedef logic [c_def_aw-1:0]   adr_t;
  typedef logic [c_def_dw-1:0]   dat_t;
  typedef logic [c_def_dw/8-1:0] sel_t;

endpackage
`default_nettype wire

// File: rtl/core2wb_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : core2wb_bridge_if                                        |
// | Description : Core request port and pipelined Wishbone master signals. |
// |               master = bridge view, slave = environment view.          |
// | Revision    : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
interface core2wb_bridge_if #(
  parameter int AW = core2wb_bridge_pkg::c_def_aw,
  parameter int DW = core2wb_bridge_pkg::c_def_dw
);

  // Core side
  logic            core_req;
  logic            core_gnt;
  logic            core_we;
  logic [DW/8-1:0] core_be;
  logic [AW-1:0]   core_addr;
  logic [DW-1:0]   core_wdata;
  logic            core_rvalid;
  logic [DW-1:0]   core_rdata;
  logic            core_err;

  // Wishbone side
  logic            wb_cyc;
  logic            wb_stb;
  logic            wb_we;
  logic [AW-1:0]   wb_adr;
  logic [DW/8-1:0] wb_sel;
  logic [DW-1:0]   wb_dat_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_ack;
  logic            wb_err;
  logic            wb_stall;

  modport master (
    input  core_req, core_we, core_be, core_addr, core_wdata,
    input  wb_dat_i, wb_ack, wb_err, wb_stall,
    output core_gnt, core_rvalid, core_rdata, core_err,
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o
  );

  modport slave (
    output core_req, core_we, core_be, core_addr, core_wdata,
    output wb_dat_i, wb_ack, wb_err, wb_stall,
    input  core_gnt, core_rvalid, core_rdata, core_err,
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o
  );

endinterface
`default_nettype wire

// File: rtl/core2wb_bridge_outstanding_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : outstanding_ctr                                          |
// | Description : Counts Wishbone transactions issued but not yet          |
// |               terminated; saturates at MAX_OUT and never underflows.   |
// | Revision    : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module outstanding_ctr
  import core2wb_bridge_pkg::*;
#(
  parameter int MAX_OUT = c_def_max_out,
  parameter int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          room
);

  localparam logic [CW-1:0] c_max = CW'(MAX_OUT);

  logic [CW-1:0] r_count;
  logic          w_inc;
  logic          w_dec;

  // Guard both directions locally so the count stays in 0..MAX_OUT even
  // if a caller asserts inc/dec at the wrong time.
  assign room  = (r_count < c_max);
  assign w_inc = inc & room;
  assign w_dec = dec & (r_count != '0);
  assign count = r_count;

  // Net +1 / -1 / hold; simultaneous inc and dec cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_inc && !w_dec) begin
      r_count <= r_count + CW'(1);
    end else if (w_dec && !w_inc) begin
      r_count <= r_count - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/core2wb_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : core2wb_bridge                                           |
// | Description : Core req/gnt/rvalid port to pipelined Wishbone B4        |
// |               master, up to MAX_OUT in flight, in-order registered     |
// |               responses.                                               |
// | Revision    : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module core2wb_bridge
  import core2wb_bridge_pkg::*;
#(
  parameter int AW      = c_def_aw,
  parameter int DW      = c_def_dw,
  parameter int MAX_OUT = c_def_max_out
) (
  input logic              clk,
  input logic              rst,
  core2wb_bridge_if.master bus
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic [CW-1:0]   w_count;
  logic            w_room;
  logic            w_busy;
  logic            w_stb;
  logic            w_acc;
  logic            w_rsp;
  logic [AW-1:0]   w_adr;
  logic [DW/8-1:0] w_sel;

  logic            r_rvalid;
  logic            r_err;
  logic [DW-1:0]   r_rdata;

  outstanding_ctr #(
    .MAX_OUT (MAX_OUT)
  ) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_acc),
    .dec   (w_rsp),
    .count (w_count),
    .room  (w_room)
  );

  // Strobe only while a slot is free; the grant is the accepted strobe.
  // Terminations with nothing outstanding are spurious and dropped.
  assign w_busy = (w_count != '0);
  assign w_stb  = bus.core_req & w_room;
  assign w_acc  = w_stb & ~bus.wb_stall;
  assign w_rsp  = (bus.wb_ack | bus.wb_err) & w_busy;

  // Request fields pass straight through; the core holds them until gnt.
  assign w_adr        = bus.core_addr;
  assign w_sel        = bus.core_be;
  assign bus.wb_adr   = w_adr;
  assign bus.wb_sel   = w_sel;
  assign bus.wb_we    = bus.core_we;
  assign bus.wb_dat_o = bus.core_wdata;
  assign bus.wb_stb   = w_stb;
  assign bus.wb_cyc   = w_stb | w_busy;
  assign bus.core_gnt = w_acc;

  assign bus.core_rvalid = r_rvalid;
  assign bus.core_err    = r_err;
  assign bus.core_rdata  = r_rdata;

  // One-cycle response stage; ack+err together is a single error response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rsp;
      r_err    <= w_rsp & bus.wb_err;
      if (w_rsp) begin
        r_rdata <= bus.wb_dat_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core2wb_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_core2wb_bridge                                        |
// | Description : Self-checking bench for core2wb_bridge: directed         |
// |               scenarios plus a randomized run against a queue model.   |
// | Revision    : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_core2wb_bridge;
  import core2wb_bridge_pkg::*;

  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  core2wb_bridge_if #(.AW(32), .DW(32)) bus ();

  core2wb_bridge #(.AW(32), .DW(32), .MAX_OUT(MAX_OUT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drive all inputs to an idle level.
  task automatic idle();
    bus.core_req   = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_be    = '0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.wb_dat_i   = '0;
    bus.wb_ack     = 1'b0;
    bus.wb_err     = 1'b0;
    bus.wb_stall   = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (bus.core_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%0h want=0", bus.core_rvalid); end
    n_tests++; if (bus.core_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0h want=0", bus.core_err); end
    n_tests++; if (bus.core_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%0h want=0", bus.core_rdata); end
    n_tests++; if (bus.wb_cyc !== 1'b0 || bus.wb_stb !== 1'b0) begin n_fail++; $display("FAIL reset_cyc_stb got=%0b%0b want=00", bus.wb_cyc, bus.wb_stb); end
    n_tests++; if (int'(u_dut.w_count) !== 0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", u_dut.w_count); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (bus.wb_cyc !== 1'b0) begin n_fail++; $display("FAIL post_reset_cyc got=%0b want=0", bus.wb_cyc); end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h100; bus.core_be = 4'hF;
    #1;
    n_tests++; if (bus.core_gnt !== 1'b1 || bus.wb_stb !== 1'b1 || bus.wb_cyc !== 1'b1) begin n_fail++; $display("FAIL rd_c0_gnt_stb_cyc got=%0b%0b%0b want=111", bus.core_gnt, bus.wb_stb, bus.wb_cyc); end
    n_tests++; if (bus.wb_adr !== 32'h100 || bus.wb_we !== 1'b0 || bus.wb_sel !== 4'hF) begin n_fail++; $display("FAIL rd_c0_fields adr=%0h we=%0b sel=%0h want 100/0/f", bus.wb_adr, bus.wb_we, bus.wb_sel); end
    @(negedge clk);
    bus.core_req = 1'b0; bus.wb_ack = 1'b1; bus.wb_dat_i = 32'hDEADBEEF;
    #1;
    n_tests++; if (bus.core_gnt !== 1'b0 || bus.wb_cyc !== 1'b1 || bus.core_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_c1 gnt/cyc/rvalid got=%0b%0b%0b want=010", bus.core_gnt, bus.wb_cyc, bus.core_rvalid); end
    @(negedge clk);
    bus.wb_ack = 1'b0; bus.wb_dat_i = 32'h0;
    #1;
    n_tests++; if (bus.core_rvalid !== 1'b1 || bus.core_err !== 1'b0) begin n_fail++; $display("FAIL rd_c2 rvalid/err got=%0b%0b want=10", bus.core_rvalid, bus.core_err); end
    n_tests++; if (bus.core_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_c2_rdata got=%0h want=deadbeef", bus.core_rdata); end
    n_tests++; if (bus.wb_cyc !== 1'b0) begin n_fail++; $display("FAIL rd_c2_cyc got=%0b want=0", bus.wb_cyc); end
    @(negedge clk);
    #1;
    n_tests++; if (bus.core_rvalid !== 1'b0 || bus.wb_cyc !== 1'b0) begin n_fail++; $display("FAIL rd_c3 rvalid/cyc got=%0b%0b want=00", bus.core_rvalid, bus.wb_cyc); end
    n_tests++; if (bus.core_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_c3_rdata_hold got=%0h want=deadbeef", bus.core_rdata); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 32'h200;
      bus.core_wdata = 32'hCAFE0000; bus.core_be = 4'h3; bus.wb_stall = 1'b1;
      #1;
      n_tests++; if (bus.core_gnt !== 1'b0 || bus.wb_stb !== 1'b1) begin n_fail++; $display("FAIL stall_c%0d gnt/stb got=%0b%0b want=01", i, bus.core_gnt, bus.wb_stb); end
      n_tests++; if (bus.wb_adr !== 32'h200 || bus.wb_dat_o !== 32'hCAFE0000 || bus.wb_sel !== 4'h3 || bus.wb_we !== 1'b1) begin n_fail++; $display("FAIL stall_c%0d_fields adr=%0h dat=%0h sel=%0h", i, bus.wb_adr, bus.wb_dat_o, bus.wb_sel); end
    end
    @(negedge clk);
    bus.wb_stall = 1'b0;
    #1;
    n_tests++; if (bus.core_gnt !== 1'b1) begin n_fail++; $display("FAIL stall_c3_gnt got=%0b want=1", bus.core_gnt); end
    @(negedge clk);
    bus.core_req = 1'b0; bus.wb_ack = 1'b1;
    @(negedge clk);
    bus.wb_ack = 1'b0;
    #1;
    n_tests++; if (bus.core_rvalid !== 1'b1 || bus.core_err !== 1'b0) begin n_fail++; $display("FAIL stall_rsp rvalid/err got=%0b%0b want=10", bus.core_rvalid, bus.core_err); end
    idle();
  endtask

  // Three writes, each acked three cycles after its grant.
  task automatic test_pipeline();
    logic [8:0] req_v, ack_v, stb_v, rv_v, cyc_v;
    int cnt [9] = '{0, 1, 2, 2, 1, 1, 1, 1, 0};
    req_v = 9'b000011111;
    ack_v = 9'b010011000;
    stb_v = 9'b000010011;
    rv_v  = 9'b100110000;
    cyc_v = 9'b011111111;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      bus.core_req  = req_v[c];
      bus.core_we   = 1'b1;
      bus.core_be   = 4'hF;
      bus.core_addr = (c == 0) ? 32'h1000 : (c == 1) ? 32'h1004 : 32'h1008;
      bus.wb_ack    = ack_v[c];
      #1;
      n_tests++; if (bus.wb_stb !== stb_v[c] || bus.core_gnt !== stb_v[c]) begin n_fail++; $display("FAIL pipe_c%0d stb/gnt got=%0b%0b want=%0b", c, bus.wb_stb, bus.core_gnt, stb_v[c]); end
      n_tests++; if (bus.wb_cyc !== cyc_v[c] || bus.core_rvalid !== rv_v[c]) begin n_fail++; $display("FAIL pipe_c%0d cyc/rvalid got=%0b%0b want=%0b%0b", c, bus.wb_cyc, bus.core_rvalid, cyc_v[c], rv_v[c]); end
      n_tests++; if (int'(u_dut.w_count) !== cnt[c]) begin n_fail++; $display("FAIL pipe_c%0d_count got=%0d want=%0d", c, u_dut.w_count, cnt[c]); end
    end
    idle();
  endtask

  // Two reads, second terminated with err.
  task automatic test_error();
    logic [4:0] req_v, ack_v, err_v, rv_v, re_v, cyc_v;
    req_v = 5'b00011; ack_v = 5'b00100; err_v = 5'b01000;
    rv_v  = 5'b11000; re_v  = 5'b10000; cyc_v = 5'b01111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.core_req  = req_v[c];
      bus.core_we   = 1'b0;
      bus.core_addr = (c == 0) ? 32'h2000 : 32'h2004;
      bus.wb_ack    = ack_v[c];
      bus.wb_err    = err_v[c];
      bus.wb_dat_i  = (c == 2) ? 32'h11112222 : 32'h33334444;
      #1;
      n_tests++; if (bus.core_rvalid !== rv_v[c] || bus.core_err !== re_v[c]) begin n_fail++; $display("FAIL err_c%0d rvalid/err got=%0b%0b want=%0b%0b", c, bus.core_rvalid, bus.core_err, rv_v[c], re_v[c]); end
      n_tests++; if (bus.wb_cyc !== cyc_v[c]) begin n_fail++; $display("FAIL err_c%0d_cyc got=%0b want=%0b", c, bus.wb_cyc, cyc_v[c]); end
      if (c == 3) begin
        n_tests++; if (bus.core_rdata !== 32'h11112222) begin n_fail++; $display("FAIL err_c3_rdata got=%0h want=11112222", bus.core_rdata); end
      end
    end
    // ack and err together: one response flagged as error
    @(negedge clk);
    bus.core_req = 1'b1;
    @(negedge clk);
    bus.core_req = 1'b0; bus.wb_ack = 1'b1; bus.wb_err = 1'b1;
    @(negedge clk);
    bus.wb_ack = 1'b0; bus.wb_err = 1'b0;
    #1;
    n_tests++; if (bus.core_rvalid !== 1'b1 || bus.core_err !== 1'b1 || int'(u_dut.w_count) !== 0) begin n_fail++; $display("FAIL ackerr rvalid/err/count got=%0b%0b%0d want=110", bus.core_rvalid, bus.core_err, u_dut.w_count); end
    idle();
  endtask

  // Grant and ack in the same cycle with one outstanding.
  task automatic test_back_to_back();
    logic [3:0] req_v, ack_v, gnt_v, rv_v;
    int cnt [4] = '{0, 1, 1, 0};
    req_v = 4'b0011; ack_v = 4'b0110; gnt_v = 4'b0011; rv_v = 4'b1100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.core_req  = req_v[c];
      bus.core_addr = 32'h3000 + 32'(c * 4);
      bus.wb_ack    = ack_v[c];
      #1;
      n_tests++; if (bus.core_gnt !== gnt_v[c] || bus.core_rvalid !== rv_v[c]) begin n_fail++; $display("FAIL b2b_c%0d gnt/rvalid got=%0b%0b want=%0b%0b", c, bus.core_gnt, bus.core_rvalid, gnt_v[c], rv_v[c]); end
      n_tests++; if (int'(u_dut.w_count) !== cnt[c]) begin n_fail++; $display("FAIL b2b_c%0d_count got=%0d want=%0d", c, u_dut.w_count, cnt[c]); end
    end
    idle();
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk); bus.core_req = 1'b1;
    @(negedge clk); bus.core_req = 1'b1;
    @(negedge clk); bus.core_req = 1'b0; rst = 1'b1;
    #1;
    n_tests++; if (int'(u_dut.w_count) !== 2) begin n_fail++; $display("FAIL rstmid_pre_count got=%0d want=2", u_dut.w_count); end
    @(negedge clk); rst = 1'b0; bus.wb_ack = 1'b1; bus.wb_dat_i = 32'h77777777;
    #1;
    n_tests++; if (bus.wb_cyc !== 1'b0 || int'(u_dut.w_count) !== 0 || bus.core_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_c3 cyc/count/rvalid got=%0b%0d%0b want=000", bus.wb_cyc, u_dut.w_count, bus.core_rvalid); end
    @(negedge clk);
    #1;
    n_tests++; if (bus.core_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_ack1 rvalid got=%0b want=0", bus.core_rvalid); end
    @(negedge clk); bus.wb_ack = 1'b0;
    #1;
    n_tests++; if (bus.core_rvalid !== 1'b0 || int'(u_dut.w_count) !== 0 || bus.wb_cyc !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_ack2 rvalid/count/cyc got=%0b%0d%0b want=000", bus.core_rvalid, u_dut.w_count, bus.wb_cyc); end
    idle();
  endtask

  task automatic test_spurious();
    @(negedge clk);
    bus.wb_ack = 1'b1; bus.wb_err = 1'b1; bus.wb_dat_i = 32'h55555555;
    #1;
    n_tests++; if (bus.wb_cyc !== 1'b0) begin n_fail++; $display("FAIL spur_cyc got=%0b want=0", bus.wb_cyc); end
    @(negedge clk);
    idle();
    #1;
    n_tests++; if (bus.core_rvalid !== 1'b0 || bus.core_err !== 1'b0 || int'(u_dut.w_count) !== 0) begin n_fail++; $display("FAIL spur_rsp rvalid/err/count got=%0b%0b%0d want=000", bus.core_rvalid, bus.core_err, u_dut.w_count); end
  endtask

  // Random traffic; the model is a queue of granted requests awaiting a
  // termination, plus the expected registered response.
  task automatic test_random();
    logic [31:0] pend [$];
    logic        hold;
    logic        e_stb, e_gnt, e_cyc, rsp;
    logic        e_rvalid, e_err;
    logic [31:0] e_rdata;
    @(negedge clk); idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    hold = 1'b0; e_rvalid = 1'b0; e_err = 1'b0; e_rdata = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!hold) begin
        bus.core_req   = ($urandom_range(0, 2) != 0);
        bus.core_we    = 1'($urandom);
        bus.core_be    = 4'($urandom);
        bus.core_addr  = $urandom & 32'hFFFF_FFFC;
        bus.core_wdata = $urandom;
      end
      bus.wb_stall = ($urandom_range(0, 3) == 0);
      bus.wb_ack   = ($urandom_range(0, 2) == 0);
      bus.wb_err   = ($urandom_range(0, 7) == 0);
      bus.wb_dat_i = $urandom;
      #1;
      e_stb = bus.core_req && (pend.size() < MAX_OUT);
      e_gnt = e_stb && !bus.wb_stall;
      e_cyc = e_stb || (pend.size() != 0);
      n_tests++; if (bus.wb_stb !== e_stb || bus.core_gnt !== e_gnt || bus.wb_cyc !== e_cyc) begin n_fail++; $display("FAIL rnd_c%0d stb/gnt/cyc got=%0b%0b%0b want=%0b%0b%0b", c, bus.wb_stb, bus.core_gnt, bus.wb_cyc, e_stb, e_gnt, e_cyc); end
      n_tests++; if (bus.core_rvalid !== e_rvalid || bus.core_err !== e_err || bus.core_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_c%0d rsp got=%0b/%0b/%0h want=%0b/%0b/%0h", c, bus.core_rvalid, bus.core_err, bus.core_rdata, e_rvalid, e_err, e_rdata); end
      n_tests++; if (int'(u_dut.w_count) !== pend.size()) begin n_fail++; $display("FAIL rnd_c%0d_count got=%0d want=%0d", c, u_dut.w_count, pend.size()); end
      if (e_stb) begin
        n_tests++; if (bus.wb_adr !== bus.core_addr || bus.wb_dat_o !== bus.core_wdata || bus.wb_sel !== bus.core_be || bus.wb_we !== bus.core_we) begin n_fail++; $display("FAIL rnd_c%0d_fields adr=%0h want=%0h", c, bus.wb_adr, bus.core_addr); end
      end
      rsp = (bus.wb_ack || bus.wb_err) && (pend.size() != 0);
      if (e_gnt) pend.push_back(bus.core_addr);
      if (rsp) void'(pend.pop_front());
      e_rvalid = rsp;
      e_err    = rsp && bus.wb_err;
      if (rsp) e_rdata = bus.wb_dat_i;
      hold = bus.core_req && !e_gnt;
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single_read();
    test_stall();
    test_pipeline();
    test_error();
    test_back_to_back();
    test_reset_mid_op();
    test_spurious();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
